// File: rtl/dense_argmax.sv
// Argmax over the dense-layer outputs RAM: streams OUT_COUNT signed scores
// through a registered read port and publishes the index of the largest one.
module dense_argmax #(
  parameter int OUT_COUNT = 10,
  parameter int DATA_SIZE = 16,
  parameter int IDX_W     = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ram_rd,
  output logic [IDX_W-1:0]     ram_adr,
  input  logic [DATA_SIZE-1:0] ram_dataOut,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [IDX_W-1:0]     class_idx,
  output logic [DATA_SIZE-1:0] class_val
);

  // states: IDLE wait | FETCH read addr 0 | SCAN read+compare | LAST compare final | DONE publish
  typedef enum logic [2:0] {IDLE, FETCH, SCAN, LAST, DONE} stateT;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_COUNT - 1);

  stateT            state, nextState;
  logic [IDX_W-1:0] adrCnt;
  logic [IDX_W-1:0] dataIdx;
  logic             evalEn;
  logic             isFirst;
  logic             isGreater;

  always_comb begin
    nextState = state;
    ram_rd    = 1'b0;
    ram_adr   = '0;
    evalEn    = 1'b0;
    dataIdx   = LAST_IDX;
    case (state)
      IDLE: begin
        if (start) nextState = FETCH;
      end
      FETCH: begin
        ram_rd    = 1'b1;
        nextState = (OUT_COUNT > 1) ? SCAN : LAST;
      end
      SCAN: begin
        ram_rd  = 1'b1;
        ram_adr = adrCnt;
        evalEn  = 1'b1;
        dataIdx = adrCnt - 1'b1;
        if (adrCnt == LAST_IDX) nextState = LAST;
      end
      LAST: begin
        evalEn    = 1'b1;
        dataIdx   = LAST_IDX;
        nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Read data lags the address by one cycle, so dataIdx names the score arriving now.
  assign isFirst   = (dataIdx == '0);
  assign isGreater = $signed(ram_dataOut) > $signed(class_val);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      adrCnt    <= '0;
      valid     <= 1'b0;
      class_idx <= '0;
      class_val <= '0;
    end else begin
      state <= nextState;

      if (state == FETCH)
        adrCnt <= IDX_W'(1);
      else if (state == SCAN && adrCnt != LAST_IDX)
        adrCnt <= adrCnt + 1'b1;

      if (state == IDLE && start)
        valid <= 1'b0;
      else if (state == LAST)
        valid <= 1'b1;

      // Strict greater-than keeps the lowest index on ties.
      if (evalEn && (isFirst || isGreater)) begin
        class_idx <= dataIdx;
        class_val <= ram_dataOut;
      end
    end
  end

endmodule

// File: tb/tb_dense_argmax.sv
// Bench for dense_argmax: a 10-score instance and a 1-score instance, each
// fed by a registered-read RAM model, with a scoreboard of expected argmax results.
module tb_dense_argmax;

  typedef struct {
    int idx;
    int val;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startA = 1'b0;
  logic startB = 1'b0;

  logic               rdA, rdB;
  logic [3:0]         adrA;
  logic [0:0]         adrB;
  logic [15:0]        dinA, dinB;
  logic               busyA, doneA, validA;
  logic               busyB, doneB, validB;
  logic [3:0]         idxA;
  logic [0:0]         idxB;
  logic signed [15:0] valA, valB;

  int scoresA [10];
  int scoreB;

  int  nChecks = 0;
  int  nBad    = 0;
  expT sbq[$];

  bit expValid [2];
  int lastIdx [2];
  int lastVal [2];

  int sRd, sAdr, sBusy, sDone, sValid, sIdx, sVal;

  dense_argmax #(.OUT_COUNT(10), .DATA_SIZE(16)) dutA (
    .clk(clk), .rst(rst), .start(startA),
    .ram_rd(rdA), .ram_adr(adrA), .ram_dataOut(dinA),
    .busy(busyA), .done(doneA), .valid(validA),
    .class_idx(idxA), .class_val(valA)
  );

  dense_argmax #(.OUT_COUNT(1), .DATA_SIZE(16)) dutB (
    .clk(clk), .rst(rst), .start(startB),
    .ram_rd(rdB), .ram_adr(adrB), .ram_dataOut(dinB),
    .busy(busyB), .done(doneB), .valid(validB),
    .class_idx(idxB), .class_val(valB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rdA) dinA <= 16'(scoresA[adrA]);
    if (rdB) dinB <= 16'(scoreB);
  end

  task automatic chk(input string tag, input int got, input int exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample(input bit sel);
    sRd    = sel ? int'(rdB)    : int'(rdA);
    sAdr   = sel ? int'(adrB)   : int'(adrA);
    sBusy  = sel ? int'(busyB)  : int'(busyA);
    sDone  = sel ? int'(doneB)  : int'(doneA);
    sValid = sel ? int'(validB) : int'(validA);
    sIdx   = sel ? int'(idxB)   : int'(idxA);
    sVal   = sel ? int'(valB)   : int'(valA);
  endtask

  task automatic setStart(input bit sel, input bit v);
    if (sel) startB = v;
    else     startA = v;
  endtask

  function automatic expT model(input bit sel);
    expT r;
    r.idx = 0;
    if (sel) begin
      r.val = scoreB;
    end else begin
      r.val = scoresA[0];
      for (int i = 1; i < 10; i++)
        if (scoresA[i] > r.val) begin
          r.idx = i;
          r.val = scoresA[i];
        end
    end
    return r;
  endfunction

  // Start one scan at the next falling edge (cycle 0) and follow it to done.
  // With extra set, start is also pulsed in cycles 4 and 12, which must be ignored.
  task automatic scanOnce(input bit sel, input bit extra);
    int  n, rdCount;
    bit  seen;
    expT e;
    n = sel ? 1 : 10;
    @(negedge clk);
    sample(sel);
    chk("idleBusy", sBusy, 0);
    chk("idleValid", sValid, int'(expValid[sel]));
    chk("holdIdx", sIdx, lastIdx[sel]);
    chk("holdVal", sVal, lastVal[sel]);
    setStart(sel, 1'b1);
    sbq.push_back(model(sel));
    @(negedge clk);
    setStart(sel, 1'b0);
    rdCount = 0;
    seen    = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      sample(sel);
      if (c == 1) begin
        chk("busyFetch", sBusy, 1);
        chk("validCleared", sValid, 0);
      end
      if (sRd != 0) begin
        chk("adrSeq", sAdr, rdCount);
        rdCount++;
      end else begin
        chk("adrIdle", sAdr, 0);
      end
      setStart(sel, extra && (c == 4 || c == 12));
      if (sDone != 0) begin
        seen = 1'b1;
        chk("doneCycle", c, n + 2);
        chk("rdLength", rdCount, n);
        chk("doneBusy", sBusy, 1);
        chk("doneValid", sValid, 1);
        e = sbq.pop_front();
        chk("classIdx", sIdx, e.idx);
        chk("classVal", sVal, e.val);
        lastIdx[sel]  = e.idx;
        lastVal[sel]  = e.val;
        expValid[sel] = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      chk("doneTimeout", 0, 1);
      setStart(sel, 1'b0);
      if (sbq.size() > 0) e = sbq.pop_front();
    end
  endtask

  initial begin
    for (int i = 0; i < 10; i++) scoresA[i] = 0;
    scoreB = 0;
    expValid[0] = 1'b0; expValid[1] = 1'b0;
    lastIdx[0] = 0; lastIdx[1] = 0;
    lastVal[0] = 0; lastVal[1] = 0;

    #3 rst = 1'b0;
    #1;
    sample(1'b0);
    chk("rstBusy", sBusy, 0);
    chk("rstRd", sRd, 0);
    chk("rstValid", sValid, 0);
    chk("rstIdx", sIdx, 0);
    chk("rstVal", sVal, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    scoresA = '{3, -7, 12, 0, 5, 99, -1, 40, 2, 8};
    scanOnce(1'b0, 1'b0);

    scoresA = '{-50, -3, -20, -3, -100, -8, -9, -4, -60, -70};
    scanOnce(1'b0, 1'b1);
    scoresA = '{-32768, 0, 0, 0, 0, 0, 0, 0, 0, 32767};
    scanOnce(1'b0, 1'b0);

    for (int i = 0; i < 10; i++) scoresA[i] = int'($urandom_range(0, 65535)) - 32768;
    scanOnce(1'b0, 1'b0);

    scoreB = -5;
    scanOnce(1'b1, 1'b0);

    // Reset in the middle of a scan (cycle 5, SCAN), asserted between clock edges.
    scoresA = '{3, -7, 12, 0, 5, 99, -1, 40, 2, 8};
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    sample(1'b0);
    chk("midRstRd", sRd, 0);
    chk("midRstAdr", sAdr, 0);
    chk("midRstBusy", sBusy, 0);
    chk("midRstDone", sDone, 0);
    chk("midRstValid", sValid, 0);
    chk("midRstIdx", sIdx, 0);
    chk("midRstVal", sVal, 0);
    sample(1'b1);
    chk("midRstValidB", sValid, 0);
    chk("midRstValB", sVal, 0);
    expValid[0] = 1'b0; expValid[1] = 1'b0;
    lastIdx[0] = 0; lastIdx[1] = 0;
    lastVal[0] = 0; lastVal[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    scanOnce(1'b0, 1'b0);
    scanOnce(1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
